// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC/nPC sequencer.
// State codes, npc source codes and default reset vectors.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DELAY = 2'b01,
        ST_ANNUL = 2'b10,
        ST_BAD   = 2'b11
    } state_e;

    localparam logic [1:0] MUX_SEQ = 2'b00;
    localparam logic [1:0] MUX_ALU = 2'b01;
    localparam logic [1:0] MUX_TA  = 2'b10;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_NPC = 32'h0000_0004;

    function automatic logic is_misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_npc_sequencer_if.sv
// Bundle of the sequencer's branch-resolution inputs and PC outputs.
// master drives CTI requests, slave is the sequencer side.
interface pc_npc_sequencer_if;

    logic        stall;
    logic        branch_valid;
    logic        branch_taken;
    logic        branch_always;
    logic        annul;
    logic        is_jmpl;
    logic [31:0] ta;
    logic [31:0] alu_out;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [1:0]  pc_mux;
    logic        le;
    logic        squash;
    logic        misaligned;
    logic [1:0]  state;

    modport master (
        output stall, branch_valid, branch_taken, branch_always,
        output annul, is_jmpl, ta, alu_out,
        input  pc, npc, pc_mux, le, squash, misaligned, state
    );

    modport slave (
        input  stall, branch_valid, branch_taken, branch_always,
        input  annul, is_jmpl, ta, alu_out,
        output pc, npc, pc_mux, le, squash, misaligned, state
    );

endinterface

// File: rtl/npc_incrementer.sv
// Sequential next-PC adder: y = a + 4, wrapping at 2^32.
// Carry out is deliberately dropped.
module npc_incrementer (
    input  logic [31:0] a,
    output logic [31:0] y
);

    assign y = a + 32'd4;

endmodule

// File: rtl/pc_npc_sequencer.sv
// SPARC-style PC/nPC sequencer with delay-slot and annul tracking.
// One-cycle latency; synchronous active-low reset.
module pc_npc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] RESET_NPC = DEF_RESET_NPC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_taken,
    input  logic        branch_always,
    input  logic        annul,
    input  logic        is_jmpl,
    input  logic [31:0] ta,
    input  logic [31:0] alu_out,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [1:0]  pc_mux,
    output logic        le,
    output logic        squash,
    output logic        misaligned,
    output logic [1:0]  state
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [1:0]  pc_mux_q, pc_mux_d;
    logic        squash_q, squash_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] npc_plus4;
    logic [31:0] target;
    logic        taken;

    npc_incrementer u_inc (
        .a (npc_q),
        .y (npc_plus4)
    );

    assign taken  = branch_valid & (branch_taken | branch_always);
    assign target = is_jmpl ? alu_out : ta;

    // Next-state and next-PC selection; stall holds, reset overrides.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        pc_mux_d     = pc_mux_q;
        squash_d     = squash_q;
        misaligned_d = misaligned_q;
        if (!reset) begin
            state_d      = ST_RUN;
            pc_d         = RESET_PC;
            npc_d        = RESET_NPC;
            pc_mux_d     = MUX_SEQ;
            squash_d     = 1'b0;
            misaligned_d = 1'b0;
        end else if (!stall) begin
            pc_d         = npc_q;
            npc_d        = npc_plus4;
            pc_mux_d     = MUX_SEQ;
            squash_d     = 1'b0;
            misaligned_d = 1'b0;
            state_d      = ST_RUN;
            unique case (state_q)
                ST_RUN, ST_DELAY: begin
                    if (taken) begin
                        npc_d        = target;
                        pc_mux_d     = is_jmpl ? MUX_ALU : MUX_TA;
                        misaligned_d = is_misaligned(target);
                        squash_d     = annul & branch_always;
                        state_d      = squash_d ? ST_ANNUL : ST_DELAY;
                    end else if (branch_valid && annul
                                 && state_q == ST_RUN) begin
                        squash_d = 1'b1;
                        state_d  = ST_ANNUL;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        npc_q        <= npc_d;
        pc_mux_q     <= pc_mux_d;
        squash_q     <= squash_d;
        misaligned_q <= misaligned_d;
    end

    assign pc         = pc_q;
    assign npc        = npc_q;
    assign pc_mux     = pc_mux_q;
    assign squash     = squash_q;
    assign misaligned = misaligned_q;
    assign state      = state_q;
    assign le         = ~stall & reset;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Scoreboard bench for pc_npc_sequencer: directed scenarios then
// random CTI traffic against a behavioural PC/nPC model.
module tb_pc_npc_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_npc_sequencer_if bus ();

    pc_npc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (bus.stall),
        .branch_valid  (bus.branch_valid),
        .branch_taken  (bus.branch_taken),
        .branch_always (bus.branch_always),
        .annul         (bus.annul),
        .is_jmpl       (bus.is_jmpl),
        .ta            (bus.ta),
        .alu_out       (bus.alu_out),
        .pc            (bus.pc),
        .npc           (bus.npc),
        .pc_mux        (bus.pc_mux),
        .le            (bus.le),
        .squash        (bus.squash),
        .misaligned    (bus.misaligned),
        .state         (bus.state)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [1:0]  mux;
        logic        le;
        logic        sq;
        logic        mis;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: mode 0 normal, 1 in delay slot, 2 annulled slot.
    logic [31:0] m_pc, m_npc;
    logic [1:0]  m_mux;
    logic        m_sq, m_mis;
    int          m_mode;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic seq_adv();
        m_pc  = m_npc;
        m_npc = m_npc + 32'd4;
        m_mux = 2'd0;
        m_mis = 1'b0;
        m_sq  = 1'b0;
    endtask

    task automatic step(input logic rst, input logic stl, input logic bv,
                        input logic bt, input logic ba, input logic an,
                        input logic jm, input logic [31:0] t,
                        input logic [31:0] a);
        exp_t        e;
        logic [31:0] tgt;
        @(negedge clk);
        reset             = rst;
        bus.stall         = stl;
        bus.branch_valid  = bv;
        bus.branch_taken  = bt;
        bus.branch_always = ba;
        bus.annul         = an;
        bus.is_jmpl       = jm;
        bus.ta            = t;
        bus.alu_out       = a;
        tgt = jm ? a : t;
        if (!rst) begin
            m_pc = 32'h0; m_npc = 32'h4; m_mux = 2'd0;
            m_sq = 1'b0; m_mis = 1'b0; m_mode = 0;
        end else if (!stl) begin
            if (m_mode == 2) begin
                seq_adv();
                m_mode = 0;
            end else if (bv && (bt || ba)) begin
                m_pc   = m_npc;
                m_npc  = tgt;
                m_mux  = jm ? 2'd1 : 2'd2;
                m_mis  = (tgt % 4) != 0;
                m_sq   = an && ba;
                m_mode = m_sq ? 2 : 1;
            end else if (bv && an && m_mode == 0) begin
                seq_adv();
                m_sq   = 1'b1;
                m_mode = 2;
            end else begin
                seq_adv();
                m_mode = 0;
            end
        end
        e.pc  = m_pc;
        e.npc = m_npc;
        e.mux = m_mux;
        e.le  = !stl && rst;
        e.sq  = m_sq;
        e.mis = m_mis;
        e.st  = 2'(m_mode);
        sb.push_back(e);
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++)
            step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    // Monitor: one expected record per edge, compared after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("npc", bus.npc, e.npc);
            chk("pc_mux", 32'(bus.pc_mux), 32'(e.mux));
            chk("le", 32'(bus.le), 32'(e.le));
            chk("squash", 32'(bus.squash), 32'(e.sq));
            chk("misaligned", 32'(bus.misaligned), 32'(e.mis));
            chk("state", 32'(bus.state), 32'(e.st));
        end
    end

    initial begin
        int budget;
        reset             = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_always = 1'b0;
        bus.annul         = 1'b0;
        bus.is_jmpl       = 1'b0;
        bus.ta            = 32'h0;
        bus.alu_out       = 32'h0;

        // reset 2 cycles, then pc 4, 8 (12 after next)
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        free_run(2);
        // taken bne at pc=8, ta=0x40 -> delay, then 0x40
        step(1, 0, 1, 1, 0, 0, 0, 32'h40, 32'h0);
        free_run(1);
        // taken branch into delay, stall 3 cycles, reset under stall
        step(1, 0, 1, 1, 0, 0, 0, 32'h200, 32'h0);
        step(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 1, 1, 1, 0, 0, 0, 32'h300, 32'h0);
        step(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 1, 1, 0, 0, 0, 32'h500, 32'h0);
        // ba,a at pc=0, ta=0x80; then jmpl to misaligned 0x102
        step(1, 0, 1, 0, 1, 1, 0, 32'h80, 32'h0);
        step(1, 0, 1, 1, 0, 0, 1, 32'h0, 32'h1234);
        step(1, 0, 1, 1, 0, 0, 1, 32'h0, 32'h102);
        free_run(2);
        // not-taken annulled branch at pc=8; branch ignored in annul
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        free_run(2);
        step(1, 0, 1, 0, 0, 1, 0, 32'h40, 32'h0);
        step(1, 0, 1, 1, 1, 0, 0, 32'h600, 32'h0);
        free_run(1);
        // npc wrap: jmpl to FFFF_FFF8, then sequential through 0
        step(1, 0, 1, 1, 0, 0, 1, 32'h0, 32'hFFFF_FFF8);
        free_run(3);
        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom),
                 $urandom, $urandom);
        end
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_npc_sequencer.md
PC_NPC_SEQUENCER -- requirements
Module: pc_npc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter RESET_NPC, default 32'h0000_0004, meaning the nPC value loaded on reset.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge; the only clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port stall  input  1  1 = hold all state this cycle.
REQ-006 SHALL have port branch_valid  input  1  a control-transfer instruction (CTI) is resolved this cycle.
REQ-007 SHALL have port branch_taken  input  1  condition outcome; qualified by branch_valid.
REQ-008 SHALL have port branch_always  input  1  CTI is unconditional (ba); qualified by branch_valid.
REQ-009 SHALL have port annul  input  1  CTI annul bit; qualified by branch_valid.
REQ-010 SHALL have port is_jmpl  input  1  target comes from alu_out, not ta; qualified by branch_valid.
REQ-011 SHALL have port ta  input  32  branch/call target address.
REQ-012 SHALL have port alu_out  input  32  register-indirect (jmpl) target.
REQ-013 SHALL have port pc  output  32  registered current PC.
REQ-014 SHALL have port npc  output  32  registered next PC.
REQ-015 SHALL have port pc_mux  output  2  registered source used for the last npc load: 00 = npc+4, 01 = alu_out, 10 = ta.
REQ-016 SHALL have port le  output  1  combinational; equals ~stall & reset.
REQ-017 SHALL have port squash  output  1  registered; 1 = the instruction at pc is annulled.
REQ-018 SHALL have port misaligned  output  1  registered; 1 = the last loaded target had bits [1:0] not equal to 00.
REQ-019 SHALL have port state  output  2  current FSM state, for debug.

Function
REQ-020 SHALL implement FSM states RUN=00, DELAY=01, ANNUL=10; code 11 is unused and SHALL recover to RUN on the next edge.
REQ-021 SHALL, when stall=1 and reset=1, hold pc, npc, state, pc_mux, squash and misaligned unchanged.
REQ-022 SHALL, in RUN without a taken CTI, load pc<=npc and npc<=npc+4, set pc_mux=00 and squash=0, and stay in RUN.
REQ-023 SHALL treat a CTI as taken when branch_taken=1 or branch_always=1.
REQ-024 SHALL, for a taken CTI in RUN or DELAY, load pc<=npc and npc<=target, where target = is_jmpl ? alu_out : ta; pc_mux SHALL be 01 or 10 accordingly.
REQ-025 SHALL, for a taken CTI with annul=0, go to DELAY with squash=0.
REQ-026 SHALL, for a taken CTI with annul=1 and branch_always=1, go to ANNUL with squash=1.
REQ-027 SHALL, for a taken CTI with annul=1 and branch_always=0, go to DELAY with squash=0.
REQ-028 SHALL, for a not-taken CTI with annul=1, sequentially advance (pc<=npc, npc<=npc+4) and go to ANNUL with squash=1.
REQ-029 SHALL, for a not-taken CTI with annul=0, behave as REQ-022.
REQ-030 SHALL, in DELAY without a taken CTI, advance sequentially per REQ-022 and return to RUN.
REQ-031 SHALL, in ANNUL, ignore branch_valid, advance sequentially, clear squash and return to RUN.
REQ-032 SHALL compute npc+4 modulo 2^32 with no carry out (32'hFFFF_FFFC + 4 = 0).
REQ-033 SHALL load targets unmodified, and SHALL set misaligned = (target[1:0] != 0) on every target load and clear it on every sequential load.
REQ-034 SHALL have latency 1: a request presented at edge N is visible on pc/npc after edge N.
REQ-035 SHALL drop a branch_valid asserted while stall=1; the requester SHALL hold branch_valid until a non-stalled cycle.

Reset
REQ-036 SHALL, when reset=0 at a rising edge, set pc=RESET_PC, npc=RESET_NPC, state=RUN, pc_mux=00, squash=0 and misaligned=0, overriding stall and branch_valid.
REQ-037 SHALL discard a pending delay-slot or annul condition when reset is asserted mid-sequence.

Structure
REQ-038 SHALL place the state encoding, the pc_mux codes and the default reset constants in shared package pc_seq_pkg.
REQ-039 SHALL use one sub-module, npc_incrementer, a combinational 32-bit +4 adder.

Verification
REQ-040 SHALL cover: reset=0 for 2 cycles then 3 free cycles -> pc = 0, 4, 8, 12; npc = pc+4 throughout.
REQ-041 SHALL cover: at pc=8, a taken bne with annul=0 and ta=0x40 -> next cycle pc=12, npc=0x40, state=DELAY, squash=0; following cycle pc=0x40, npc=0x44, state=RUN.
REQ-042 SHALL cover: at pc=8, a not-taken branch with annul=1 -> next cycle pc=12, squash=1, state=ANNUL, with branch_valid ignored that cycle; following cycle pc=16, squash=0.
REQ-043 SHALL cover: ba,a with ta=0x80 at pc=0 -> next cycle squash=1, npc=0x80; jmpl with alu_out=0x102 -> pc_mux=01 and misaligned=1.
REQ-044 SHALL cover: stall=1 for 3 cycles in DELAY -> all outputs frozen and le=0; then reset=0 while stall=1 -> pc=0, npc=4, state=RUN.
REQ-045 SHALL cover: npc=32'hFFFF_FFFC in RUN -> next cycle pc=32'hFFFF_FFFC and npc=0.
